// File: rtl/ethpipe_csr.sv
// BAR0 control/status registers for an N-channel ethpipe: timestamp with atomic
// snapshot, per-channel DMA/TX ring pointers, RX event counters and interrupt aggregation.
`timescale 1ns/1ps
module ethpipe_csr #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned PTR_W   = 14,
  parameter logic [7:0]  VERSION = 8'h02
) (
  input  logic                   clk_125,
  input  logic                   sys_rst_n,
  input  logic                   slv_bar_hit,
  input  logic                   slv_ce_i,
  input  logic                   slv_we_i,
  input  logic [10:0]            slv_adr_i,
  input  logic [15:0]            slv_dat_i,
  input  logic [1:0]             slv_sel_i,
  output logic [15:0]            slv_dat_o,
  output logic [63:0]            global_counter,
  output logic [19:0]            dma_length,
  output logic [NCH*30-1:0]      dma_addr_start,
  input  logic [NCH*30-1:0]      dma_addr_cur,
  output logic [NCH*PTR_W-1:0]   tx_wr_ptr,
  input  logic [NCH*PTR_W-1:0]   tx_rd_ptr,
  input  logic [NCH-1:0]         ch_event,
  input  logic [NCH-1:0]         ch_intr_req,
  output logic                   sys_intr
);

  localparam logic [10:0] ADR_CH_END = 11'(32 + 8*NCH);

  function automatic logic [15:0] f_merge(input logic [15:0] old_v,
                                          input logic [15:0] new_v,
                                          input logic [15:0] msk);
    return (old_v & ~msk) | (new_v & msk);
  endfunction

  function automatic logic [29:0] f_start_rst(input int unsigned k);
    logic [31:0] a;
    a = 32'h1000_0000 + 32'(k) * 32'h0010_0000;
    return a[31:2];
  endfunction

  logic        w_acc, w_wr, w_rd;
  logic [15:0] w_wval, w_bmask;
  logic        w_ch_hit;
  logic [2:0]  w_ch_idx, w_ch_sub;

  logic [63:0]      r_cnt;
  logic [47:0]      r_shadow;
  logic [19:0]      r_dma_len;
  logic [29:0]      r_start [NCH];
  logic [PTR_W-1:0] r_wr_ptr [NCH];
  logic [15:0]      r_evt [NCH];
  logic [NCH-1:0]   r_int_stat, r_int_mask;
  logic [15:0]      r_dat_o;
  logic             r_intr;

  logic [15:0]    w_len_lo_m, w_len_hi_m, w_mask_m, w_clr, w_rdata;
  logic [15:0]    w_start_lo_m [NCH];
  logic [15:0]    w_start_hi_m [NCH];
  logic [15:0]    w_ptr_m [NCH];
  logic [NCH-1:0] w_sel_ch, w_evt_rd;

  assign w_acc    = slv_ce_i & slv_bar_hit;
  assign w_wr     = w_acc & slv_we_i;
  assign w_rd     = w_acc & ~slv_we_i;
  // Bus lanes are byte-swapped relative to the register value
  assign w_wval   = {slv_dat_i[7:0], slv_dat_i[15:8]};
  assign w_bmask  = {{8{slv_sel_i[0]}}, {8{slv_sel_i[1]}}};
  assign w_ch_hit = (slv_adr_i >= 11'h020) && (slv_adr_i < ADR_CH_END);
  assign w_ch_idx = 3'(slv_adr_i[6:3] - 4'd4);
  assign w_ch_sub = slv_adr_i[2:0];

  always_comb begin
    w_len_lo_m = f_merge({r_dma_len[13:0], 2'b00}, w_wval, w_bmask);
    w_len_hi_m = f_merge({10'd0, r_dma_len[19:14]}, w_wval, w_bmask);
    w_mask_m   = f_merge(16'(r_int_mask), w_wval, w_bmask);
    w_clr      = (w_wr && slv_adr_i == 11'h008) ? (w_wval & w_bmask) : 16'h0000;
    w_sel_ch   = '0;
    w_evt_rd   = '0;
    for (int k = 0; k < NCH; k++) begin
      w_sel_ch[k]     = w_ch_hit && (w_ch_idx == 3'(k));
      w_evt_rd[k]     = w_rd && w_sel_ch[k] && (w_ch_sub == 3'd6);
      w_start_lo_m[k] = f_merge({r_start[k][13:0], 2'b00}, w_wval, w_bmask);
      w_start_hi_m[k] = f_merge(r_start[k][29:14], w_wval, w_bmask);
      w_ptr_m[k]      = f_merge(16'(r_wr_ptr[k]), w_wval, w_bmask);
    end
  end

  always_comb begin
    w_rdata = 16'h0000;
    case (slv_adr_i)
      11'h000: w_rdata = {8'(NCH), VERSION};
      11'h002: w_rdata = r_cnt[15:0];
      11'h003: w_rdata = r_shadow[15:0];
      11'h004: w_rdata = r_shadow[31:16];
      11'h005: w_rdata = r_shadow[47:32];
      11'h008: w_rdata = 16'(r_int_stat);
      11'h009: w_rdata = 16'(r_int_mask);
      11'h00A: w_rdata = {r_dma_len[13:0], 2'b00};
      11'h00B: w_rdata = {10'd0, r_dma_len[19:14]};
      default: ;
    endcase
    for (int k = 0; k < NCH; k++) begin
      if (w_sel_ch[k]) begin
        case (w_ch_sub)
          3'd0: w_rdata = {r_start[k][13:0], 2'b00};
          3'd1: w_rdata = r_start[k][29:14];
          3'd2: w_rdata = {dma_addr_cur[30*k +: 14], 2'b00};
          3'd3: w_rdata = dma_addr_cur[30*k+14 +: 16];
          3'd4: w_rdata = 16'(r_wr_ptr[k]);
          3'd5: w_rdata = 16'(tx_rd_ptr[PTR_W*k +: PTR_W]);
          3'd6: w_rdata = r_evt[k];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_dma_len  <= 20'h04000;
      r_int_stat <= '0;
      r_int_mask <= '1;
      r_dat_o    <= '0;
      r_intr     <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_start[k]  <= f_start_rst(k);
        r_wr_ptr[k] <= '0;
        r_evt[k]    <= '0;
      end
    end else begin
      r_cnt <= r_cnt + 64'd1;
      // Reading the low word freezes the upper 48 bits for the following reads
      if (w_rd && slv_adr_i == 11'h002) r_shadow <= r_cnt[63:16];
      if (w_rd) r_dat_o <= {w_rdata[7:0], w_rdata[15:8]};
      r_int_stat <= (r_int_stat & ~w_clr[NCH-1:0]) | ch_intr_req;
      r_intr     <= |(r_int_stat & r_int_mask);
      if (w_wr) begin
        case (slv_adr_i)
          11'h009: r_int_mask        <= w_mask_m[NCH-1:0];
          11'h00A: r_dma_len[13:0]   <= w_len_lo_m[15:2];
          11'h00B: r_dma_len[19:14]  <= w_len_hi_m[5:0];
          default: ;
        endcase
      end
      for (int k = 0; k < NCH; k++) begin
        if (w_wr && w_sel_ch[k]) begin
          case (w_ch_sub)
            3'd0: r_start[k][13:0]  <= w_start_lo_m[k][15:2];
            3'd1: r_start[k][29:14] <= w_start_hi_m[k];
            3'd4: r_wr_ptr[k]       <= w_ptr_m[k][PTR_W-1:0];
            default: ;
          endcase
        end
        // A read clears the count but must not drop an event arriving in the same cycle
        if (w_evt_rd[k])
          r_evt[k] <= {15'd0, ch_event[k]};
        else if (ch_event[k] && r_evt[k] != 16'hFFFF)
          r_evt[k] <= r_evt[k] + 16'd1;
      end
    end
  end

  assign slv_dat_o      = r_dat_o;
  assign global_counter = r_cnt;
  assign dma_length     = r_dma_len;
  assign sys_intr       = r_intr;

  for (genvar g = 0; g < NCH; g++) begin : g_ch_out
    assign dma_addr_start[30*g +: 30]  = r_start[g];
    assign tx_wr_ptr[PTR_W*g +: PTR_W] = r_wr_ptr[g];
  end

endmodule

// File: tb/tb_ethpipe_csr.sv
// Scoreboard bench for ethpipe_csr: read expectations are queued when the access is
// driven and compared when the registered read data appears.
`timescale 1ns/1ps
module tb_ethpipe_csr;
  localparam int NCH   = 2;
  localparam int PTR_W = 14;
  localparam logic [29:0] CUR0 = 30'h2345_6789;
  localparam logic [29:0] CUR1 = 30'h0ABC_DEF0;
  localparam logic [13:0] RDP0 = 14'h1ABC;
  localparam logic [13:0] RDP1 = 14'h0123;

  logic                 clk_125 = 1'b0;
  logic                 sys_rst_n = 1'b0;
  logic                 slv_bar_hit = 1'b0, slv_ce_i = 1'b0, slv_we_i = 1'b0;
  logic [10:0]          slv_adr_i = '0;
  logic [15:0]          slv_dat_i = '0;
  logic [1:0]           slv_sel_i = '0;
  logic [15:0]          slv_dat_o;
  logic [63:0]          global_counter;
  logic [19:0]          dma_length;
  logic [NCH*30-1:0]    dma_addr_start, dma_addr_cur;
  logic [NCH*PTR_W-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [NCH-1:0]       ch_event, ch_intr_req;
  logic                 sys_intr;
  logic                 ev0 = 1'b0, ev1 = 1'b0, irq0 = 1'b0, irq1 = 1'b0;

  assign ch_event     = {ev1, ev0};
  assign ch_intr_req  = {irq1, irq0};
  assign dma_addr_cur = {CUR1, CUR0};
  assign tx_rd_ptr    = {RDP1, RDP0};

  ethpipe_csr #(.NCH(NCH), .PTR_W(PTR_W), .VERSION(8'h02)) dut (
    .clk_125(clk_125), .sys_rst_n(sys_rst_n), .slv_bar_hit(slv_bar_hit),
    .slv_ce_i(slv_ce_i), .slv_we_i(slv_we_i), .slv_adr_i(slv_adr_i),
    .slv_dat_i(slv_dat_i), .slv_sel_i(slv_sel_i), .slv_dat_o(slv_dat_o),
    .global_counter(global_counter), .dma_length(dma_length),
    .dma_addr_start(dma_addr_start), .dma_addr_cur(dma_addr_cur),
    .tx_wr_ptr(tx_wr_ptr), .tx_rd_ptr(tx_rd_ptr), .ch_event(ch_event),
    .ch_intr_req(ch_intr_req), .sys_intr(sys_intr)
  );

  always #4 clk_125 = ~clk_125;

  int n_chk = 0;
  int n_fail = 0;
  string       tag_q[$];
  logic [15:0] exp_q[$];
  logic        rd_pend = 1'b0;
  logic [63:0] m_cnt;
  logic        bg_done = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sw(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  always @(posedge clk_125 or negedge sys_rst_n)
    if (!sys_rst_n) m_cnt <= '0;
    else            m_cnt <= m_cnt + 64'd1;

  always @(negedge clk_125) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) check_val("sb_underflow", 64'd1, 64'd0);
      else check_val(tag_q.pop_front(), 64'(slv_dat_o), 64'(exp_q.pop_front()));
    end
    rd_pend = sys_rst_n & slv_ce_i & slv_bar_hit & ~slv_we_i;
  end

  task automatic bus_op(input logic we, input logic [10:0] adr, input logic [15:0] val,
                        input logic [1:0] sel, input logic ev, input logic irq, input string tag);
    @(posedge clk_125); #1;
    slv_ce_i = 1'b1; slv_bar_hit = 1'b1; slv_we_i = we; slv_adr_i = adr;
    slv_sel_i = sel; slv_dat_i = we ? sw(val) : 16'h0000; ev0 = ev; irq0 = irq;
    if (!we) begin tag_q.push_back(tag); exp_q.push_back(sw(val)); end
    @(posedge clk_125); #1;
    slv_ce_i = 1'b0; slv_bar_hit = 1'b0; slv_we_i = 1'b0; ev0 = 1'b0; irq0 = 1'b0;
  endtask

  task automatic rd(input logic [10:0] adr, input logic [15:0] exp, input string tag);
    bus_op(1'b0, adr, exp, 2'b11, 1'b0, 1'b0, tag);
  endtask

  task automatic wr(input logic [10:0] adr, input logic [15:0] val, input logic [1:0] sel);
    bus_op(1'b1, adr, val, sel, 1'b0, 1'b0, "wr");
  endtask

  task automatic rd_ts(output logic [63:0] snap);
    @(posedge clk_125); #1;
    snap = m_cnt;
    slv_ce_i = 1'b1; slv_bar_hit = 1'b1; slv_we_i = 1'b0; slv_adr_i = 11'h002; slv_sel_i = 2'b11;
    tag_q.push_back("ts_lo"); exp_q.push_back(sw(snap[15:0]));
    @(posedge clk_125); #1;
    slv_ce_i = 1'b0; slv_bar_hit = 1'b0;
  endtask

  initial begin
    #792000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] snap_a, snap_b;
    repeat (3) @(posedge clk_125);
    #1 sys_rst_n = 1'b1;
    @(negedge clk_125);
    check_val("rst_dat_o", 64'(slv_dat_o), 64'h0);
    check_val("rst_len_port", 64'(dma_length), 64'h04000);
    check_val("rst_start_port", 64'(dma_addr_start), {4'h0, 30'h0404_0000, 30'h0400_0000});
    check_val("rst_wr_ptr", 64'(tx_wr_ptr), 64'h0);
    check_val("rst_intr", 64'(sys_intr), 64'h0);

    rd(11'h000, 16'h0202, "id");
    rd(11'h00A, 16'h0000, "len_lo_rst");
    rd(11'h00B, 16'h0001, "len_hi_rst");
    rd(11'h020, 16'h0000, "ch0_start_lo_rst");
    rd(11'h021, 16'h1000, "ch0_start_hi_rst");
    rd(11'h028, 16'h0000, "ch1_start_lo_rst");
    rd(11'h029, 16'h1010, "ch1_start_hi_rst");
    rd(11'h009, 16'h0003, "mask_rst");
    rd(11'h026, 16'h0000, "evt0_rst");

    fork
      begin
        @(posedge clk_125); #1 ev1 = 1'b1;
        repeat (70000) @(posedge clk_125);
        #1 ev1 = 1'b0;
        bg_done = 1'b1;
      end
    join_none

    rd(11'h022, {CUR0[13:0], 2'b00}, "ch0_cur_lo");
    rd(11'h023, CUR0[29:14], "ch0_cur_hi");
    rd(11'h025, 16'(RDP0), "ch0_rdptr");
    rd(11'h02B, CUR1[29:14], "ch1_cur_hi");
    rd(11'h02D, 16'(RDP1), "ch1_rdptr");

    wr(11'h024, 16'h00AB, 2'b10);
    wr(11'h024, 16'h3300, 2'b01);
    rd(11'h024, 16'h33AB, "wrptr0_bytes");
    check_val("wrptr0_port", 64'(tx_wr_ptr[13:0]), 64'h33AB);
    wr(11'h02C, 16'hFFFF, 2'b11);
    rd(11'h02C, 16'h3FFF, "wrptr1_masked");

    wr(11'h021, 16'hDEAD, 2'b11);
    wr(11'h020, 16'hBEEF, 2'b11);
    rd(11'h020, 16'hBEEC, "ch0_start_lo");
    rd(11'h021, 16'hDEAD, "ch0_start_hi");
    check_val("ch0_start_port", 64'(dma_addr_start[29:0]), 64'({16'hDEAD, 14'h2FBB}));

    wr(11'h00A, 16'h1234, 2'b11);
    rd(11'h00A, 16'h1234, "len_lo");
    wr(11'h00B, 16'h00FF, 2'b11);
    rd(11'h00B, 16'h003F, "len_hi");
    check_val("len_port", 64'(dma_length), 64'hFC48D);

    wr(11'h009, 16'h0001, 2'b11);
    @(posedge clk_125); #1 irq1 = 1'b1;
    @(posedge clk_125); #1 irq1 = 1'b0;
    repeat (3) @(negedge clk_125);
    check_val("intr_masked", 64'(sys_intr), 64'h0);
    rd(11'h008, 16'h0002, "stat_bit1");
    @(posedge clk_125); #1 irq0 = 1'b1;
    @(posedge clk_125); #1 irq0 = 1'b0;
    @(negedge clk_125);
    check_val("intr_not_yet", 64'(sys_intr), 64'h0);
    @(negedge clk_125);
    check_val("intr_asserted", 64'(sys_intr), 64'h1);
    bus_op(1'b1, 11'h008, 16'h0001, 2'b11, 1'b0, 1'b1, "w1c_set_wins");
    rd(11'h008, 16'h0003, "stat_set_wins");
    wr(11'h008, 16'h0003, 2'b01);
    rd(11'h008, 16'h0003, "stat_lane_gated");
    wr(11'h008, 16'h0001, 2'b10);
    rd(11'h008, 16'h0002, "stat_cleared0");
    repeat (2) @(negedge clk_125);
    check_val("intr_deasserted", 64'(sys_intr), 64'h0);
    wr(11'h009, 16'h0003, 2'b11);
    repeat (2) @(negedge clk_125);
    check_val("intr_unmasked1", 64'(sys_intr), 64'h1);
    wr(11'h008, 16'h0003, 2'b11);

    repeat (3) begin
      @(posedge clk_125); #1 ev0 = 1'b1;
      @(posedge clk_125); #1 ev0 = 1'b0;
    end
    bus_op(1'b0, 11'h026, 16'h0003, 2'b11, 1'b1, 1'b0, "evt_coincident");
    rd(11'h026, 16'h0001, "evt_after_clear");

    while (m_cnt < 64'hFF80) begin @(posedge clk_125); #1; end
    rd_ts(snap_a);
    repeat (100) @(posedge clk_125);
    rd(11'h003, snap_a[31:16], "snapA_w1");
    rd(11'h004, snap_a[47:32], "snapA_w2");
    rd(11'h005, snap_a[63:48], "snapA_w3");
    while (m_cnt < 64'hFFFF) begin @(posedge clk_125); #1; end
    rd_ts(snap_b);
    repeat (100) @(posedge clk_125);
    rd(11'h003, snap_b[31:16], "snapB_carry");
    rd(11'h004, snap_b[47:32], "snapB_w2");
    @(negedge clk_125);
    check_val("counter_port", global_counter, m_cnt);

    for (int i = 0; i < 80000 && !bg_done; i++) @(posedge clk_125);
    if (!bg_done) check_val("bg_timeout", 64'd0, 64'd1);
    #2;
    rd(11'h02E, 16'hFFFF, "evt1_saturated");
    rd(11'h02E, 16'h0000, "evt1_cleared");

    @(posedge clk_125); #1;
    slv_ce_i = 1'b1; slv_bar_hit = 1'b1; slv_we_i = 1'b1; slv_adr_i = 11'h00A;
    slv_sel_i = 2'b11; slv_dat_i = sw(16'h5554);
    #3 sys_rst_n = 1'b0;
    #2 slv_ce_i = 1'b0; slv_bar_hit = 1'b0; slv_we_i = 1'b0;
    repeat (2) @(posedge clk_125);
    #1 sys_rst_n = 1'b1;
    @(negedge clk_125);
    check_val("len_after_reset", 64'(dma_length), 64'h04000);
    check_val("wrptr_after_reset", 64'(tx_wr_ptr), 64'h0);
    check_val("counter_after_reset", global_counter, m_cnt);
    rd(11'h00A, 16'h0000, "len_lo_after_reset");
    rd(11'h009, 16'h0003, "mask_after_reset");

    wr(11'h038, 16'h5678, 2'b11);
    rd(11'h038, 16'h0000, "unmapped_k3");
    rd(11'h028, 16'h0000, "ch1_untouched");
    check_val("start_port_untouched", 64'(dma_addr_start), {4'h0, 30'h0404_0000, 30'h0400_0000});

    repeat (3) @(negedge clk_125);
    check_val("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
